// File: rtl/rns_residue_generator.sv
`default_nettype none
// ============================================================================
// Module   : rns_residue_generator
// Purpose  : Forward RNS converter. Reduces a VALUE_W-bit binary integer
//            modulo NUM_CH independent MOD_W-bit moduli by bit-serial
//            restoring division. All channels run in parallel. The residue
//            vector is emitted together with the moduli it was computed
//            against, so the downstream CRT stage gets a matched {m, x} pair.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous, active-low reset
//            in_valid  / in_ready  - input handshake (value, m)
//            value     - integer to reduce
//            m         - packed moduli, channel c at m[c*MOD_W +: MOD_W]
//            out_valid / out_ready - output handshake (x, m_out, zero_mod)
//            x         - packed residues, channel c = value mod m[c]
//            m_out     - moduli latched at accept
//            zero_mod  - bit c set when modulus c was zero
// Revision : 1.0 - initial release
// ============================================================================
module rns_residue_generator #(
  parameter int VALUE_W = 16,
  parameter int NUM_CH  = 4,
  parameter int MOD_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VALUE_W-1:0]        value,
  input  logic [NUM_CH*MOD_W-1:0]   m,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*MOD_W-1:0]   x,
  output logic [NUM_CH*MOD_W-1:0]   m_out,
  output logic [NUM_CH-1:0]         zero_mod
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [VALUE_W-1:0]      shift_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_CH*MOD_W-1:0] rem_q, rem_d;
  logic [NUM_CH*MOD_W-1:0] x_q, x_d;
  logic [NUM_CH*MOD_W-1:0] m_q;
  logic [NUM_CH-1:0]       zm_q, zm_d;

  logic accept;
  logic last_step;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  // Per-channel restoring-division step and result selection.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [MOD_W:0]   t;
    logic [MOD_W:0]   m_ext;
    logic [MOD_W-1:0] m_c;

    assign m_c   = m_q[c*MOD_W +: MOD_W];
    assign t     = {rem_q[c*MOD_W +: MOD_W], shift_q[VALUE_W-1]};
    assign m_ext = {1'b0, m_c};

    // The compare is done at full MOD_W+1 width. When t >= m the difference
    // is below m and so fits in MOD_W bits; its low bits are exact, so the
    // subtract only needs the low MOD_W bits of t.
    assign rem_d[c*MOD_W +: MOD_W] = (t >= m_ext) ? (t[MOD_W-1:0] - m_c)
                                                  : t[MOD_W-1:0];

    // A zero modulus makes the division meaningless; report residue 0.
    assign x_d[c*MOD_W +: MOD_W] = zm_q[c] ? '0 : rem_d[c*MOD_W +: MOD_W];

    assign zm_d[c] = (m[c*MOD_W +: MOD_W] == '0);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      x_q     <= '0;
      m_q     <= '0;
      zm_q    <= '0;
    end else if (accept) begin
      shift_q <= value;
      m_q     <= m;
      rem_q   <= '0;
      cnt_q   <= '0;
      zm_q    <= zm_d;
    end else if (state_q == S_RUN) begin
      shift_q <= shift_q << 1;
      rem_q   <= rem_d;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_step) begin
        x_q <= x_d;
      end
    end
  end

  assign x        = x_q;
  assign m_out    = m_q;
  assign zero_mod = zm_q;

endmodule
`default_nettype wire

// File: tb/tb_rns_residue_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_rns_residue_generator
// Purpose  : Directed self-checking bench for rns_residue_generator with
//            hand-computed residues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rns_residue_generator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic [15:0] m;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic [15:0] m_out;
  logic [3:0]  zero_mod;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  rns_residue_generator #(.VALUE_W(16), .NUM_CH(4), .MOD_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .m         (m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .m_out     (m_out),
    .zero_mod  (zero_mod)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at the negedge following the accept edge; returns the number of
  // negedges until out_valid is seen (bounded).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  logic [15:0] bb_val [3];
  logic [15:0] bb_m   [3];
  logic [15:0] bb_x   [3];
  logic [3:0]  bb_zm  [3];

  initial begin
    int cyc;
    int t_acc [3];
    bit seen;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    value     = '0;
    m         = '0;

    // ---------------- reset state ----------------
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_x",         {16'd0, x},         32'd0);
    check("rst_m_out",     {16'd0, m_out},     32'd0);
    check("rst_zero_mod",  {28'd0, zero_mod},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- basic: 1000 mod {5,7,9,11} ----------------
    value = 16'd1000; m = 16'hB975; in_valid = 1'b1;
    check("basic_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("basic_busy", {31'd0, in_ready}, 32'd0);
    wait_valid(cyc);
    check("basic_latency", cyc, 32'd16);
    check("basic_x",        {16'd0, x},        32'h0000_A160);
    check("basic_m_out",    {16'd0, m_out},    32'h0000_B975);
    check("basic_zero_mod", {28'd0, zero_mod}, 32'd0);
    @(negedge clk);
    check("basic_back_idle",  {31'd0, in_ready},  32'd1);
    check("basic_valid_drop", {31'd0, out_valid}, 32'd0);

    // ---------------- full scale: 65535 mod {3,7,11,13} ----------------
    value = 16'hFFFF; m = 16'hDB73; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("full_latency", cyc, 32'd16);
    check("full_x",        {16'd0, x},        32'h0000_2810);
    check("full_zero_mod", {28'd0, zero_mod}, 32'd0);
    @(negedge clk);

    // ---------------- zero modulus: 100 mod {5,3,7,0} ----------------
    value = 16'd100; m = 16'h0735; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(cyc);
    check("zmod_latency", cyc, 32'd16);
    check("zmod_x",        {16'd0, x},        32'h0000_0210);
    check("zmod_m_out",    {16'd0, m_out},    32'h0000_0735);
    check("zmod_zero_mod", {28'd0, zero_mod}, 32'h8);
    @(negedge clk);

    // ---------------- backpressure: 100 mod {5,7,9,11} ----------------
    out_ready = 1'b0;
    value = 16'd100; m = 16'hB975; in_valid = 1'b1;
    @(negedge clk);
    // Keep in_valid high with different data; it must not be taken early.
    value = 16'd1000;
    wait_valid(cyc);
    check("bp_latency", cyc, 32'd16);
    check("bp_x", {16'd0, x}, 32'h0000_1120);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_x",     {16'd0, x},         32'h0000_1120);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idle",  {31'd0, in_ready},  32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accept", {31'd0, in_ready}, 32'd0);
    wait_valid(cyc);
    check("bp_second_latency", cyc, 32'd16);
    check("bp_second_x", {16'd0, x}, 32'h0000_A160);
    @(negedge clk);

    // ---------------- reset mid-RUN ----------------
    value = 16'd100; m = 16'h0735; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    check("mrst_x",         {16'd0, x},         32'd0);
    check("mrst_m_out",     {16'd0, m_out},     32'd0);
    check("mrst_zero_mod",  {28'd0, zero_mod},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("mrst_no_valid", {31'd0, seen}, 32'd0);
    check("mrst_idle",     {31'd0, in_ready}, 32'd1);

    // ---------------- back-to-back ----------------
    bb_val[0] = 16'd1000;  bb_m[0] = 16'hB975; bb_x[0] = 16'hA160; bb_zm[0] = 4'h0;
    bb_val[1] = 16'hFFFF;  bb_m[1] = 16'h1111; bb_x[1] = 16'h0000; bb_zm[1] = 4'h0;
    bb_val[2] = 16'd100;   bb_m[2] = 16'h0735; bb_x[2] = 16'h0210; bb_zm[2] = 4'h8;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      value = bb_val[i]; m = bb_m[i]; in_valid = 1'b1;
      @(negedge clk);
      t_acc[i] = edge_cnt;
      check("bb_accepted", {31'd0, in_ready}, 32'd0);
      wait_valid(cyc);
      check("bb_latency", cyc, 32'd16);
      check("bb_x",        {16'd0, x},        {16'd0, bb_x[i]});
      check("bb_zero_mod", {28'd0, zero_mod}, {28'd0, bb_zm[i]});
      @(negedge clk);
      check("bb_idle", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    check("bb_period_01", t_acc[1] - t_acc[0], 32'd18);
    check("bb_period_12", t_acc[2] - t_acc[1], 32'd18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rns_residue_generator.md
# rns_residue_generator

Forward RNS converter that sits directly upstream of the CRT reconstruction stage. It accepts a binary integer and a packed set of four 4-bit moduli, and reduces the integer modulo each modulus. Reduction is bit-serial restoring division, run on all channels in parallel. It emits the packed residue vector `x` together with the moduli `m_out` it was computed against, so the downstream CRT stage receives a matched `{m, x}` pair under a valid/ready handshake.

## Interface
- `VALUE_W`, 16: width of the input integer; also the number of iteration cycles.
- `NUM_CH`, 4: number of residue channels.
- `MOD_W`, 4: width of each modulus and residue.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low (`reset` = 0 clears all state immediately).
- `in_valid` input 1: `value`/`m` are valid.
- `in_ready` output 1: block can accept; equals (state == IDLE).
- `value` input `VALUE_W`: integer to reduce.
- `m` input `NUM_CH*MOD_W`: packed moduli; channel c occupies `m[c*MOD_W +: MOD_W]`.
- `out_valid` output 1: `x`, `m_out` and `zero_mod` are valid.
- `out_ready` input 1: downstream accepts.
- `x` output `NUM_CH*MOD_W`: packed residues; channel c is `value mod m[c]`.
- `m_out` output `NUM_CH*MOD_W`: moduli latched at accept.
- `zero_mod` output `NUM_CH`: bit c set if modulus c was 0.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: `in_ready` = 1. An accept occurs on an edge where `in_valid` & `in_ready`. On accept:
  - latch `value` into a shift register and `m` into `m_out`;
  - clear all remainders to 0 and the counter to 0;
  - compute `zero_mod[c]` = (`m[c]` == 0);
  - go to RUN.
- RUN: each edge, for every channel c:
  - form t = {rem_c, msb of shift register}, `MOD_W`+1 bits;
  - rem_c <= (t >= m_c) ? t − m_c : t;
  - shift the register left by 1 and increment the counter.
- RUN ends on the edge where the counter equals `VALUE_W`−1. On that edge, `x` is loaded with the final remainders and the state goes to DONE.
- Width rule: the remainder register is `MOD_W` bits. The compare and subtract use `MOD_W`+1 bits, so no overflow is possible for m ≥ 1.
- Zero modulus: the channel's residue is forced to 0 and `zero_mod[c]` = 1. Other channels are unaffected.
- Modulus 1 yields residue 0 naturally and does not set `zero_mod`.
- DONE: `out_valid` = 1. `x`, `m_out` and `zero_mod` are held stable until `out_valid` & `out_ready`; on that edge the state returns to IDLE.
- `in_valid` is ignored outside IDLE; no input is buffered.

## Timing
- Reset values: `out_valid` = 0, `x` = 0, `m_out` = 0, `zero_mod` = 0, state = IDLE, so `in_ready` = 1.
- Latency: `out_valid` rises exactly `VALUE_W` cycles after the accept edge (16 with defaults).
- Throughput: one conversion per `VALUE_W`+2 cycles with `out_ready` tied high (accept, 16 RUN edges with the last loading DONE, one handshake edge, then IDLE).
- `in_ready` is low from the accept edge until the edge after the output handshake.
- Backpressure: DONE persists indefinitely while `out_ready` = 0. Outputs do not change during backpressure.
- `out_ready` asserted in IDLE or RUN has no effect.
- Reset asserted mid-RUN or in DONE:
  - immediate return to IDLE with all outputs at reset values;
  - the partial result is discarded;
  - no `out_valid` pulse follows reset release.

## Test plan
- Basic reduction:
  - stimulus: `value` = 1000, `m` = 16'hB975 (moduli 5, 7, 9, 11);
  - response: `out_valid` 16 cycles after accept, `x` = 16'hA160, `m_out` = 16'hB975, `zero_mod` = 0.
- Full-scale operand:
  - stimulus: `value` = 16'hFFFF, `m` = 16'hDB73 (moduli 3, 7, 11, 13);
  - response: `x` = 16'h2810.
- Zero modulus:
  - stimulus: `value` = 100, `m` = 16'h0735;
  - response: `x` = 16'h0210, `zero_mod` = 4'b1000.
- Backpressure:
  - stimulus: hold `out_ready` = 0 for 5 cycles after `out_valid` rises, with `in_valid` held high;
  - response: `x` stable, `in_ready` = 0, no second accept;
  - after `out_ready` = 1: IDLE on the next edge, and `in_ready` = 1, which allows the second accept.
- Reset mid-RUN:
  - stimulus: drop `reset` at the 8th RUN cycle;
  - response: outputs cleared immediately, `in_ready` = 1, and no `out_valid` within 20 cycles after release.
- Back-to-back:
  - stimulus: 3 consecutive conversions with `out_ready` = 1, including `m` = 16'h1111;
  - response: each completes in 18 cycles, and the all-ones-modulus case gives `x` = 0 with `zero_mod` = 0.
